// File: rtl/writeback_multi.sv
// Writeback stage: multi-port GPR write, sized/signed load extraction, core run state.
// Latency: write enables and values are combinational (forwarding); wb_* copies appear one clk_en cycle later.
// Backpressure: stall_out holds the upstream slot while a load waits on memory and while sleeping or halted.
//
// Ports:
//   clk, rst_n, clk_en      - clock, async active-low reset, stage advance enable
//   bubble_in               - slot is empty (live = !bubble_in)
//   wr_req/tgt_in/alu_result- per-port write request, target register, ALU value
//   is_load, load_size, load_signed, addr_lo, mem_valid, mem_result - load completion on port 0
//   exc_in, tgts_cr, event_op, wake_in - exception code, CR target, control event, wake request
//   stall_out, we, result_out          - combinational stall, write enables, write values
//   wb_tgt_out, wb_result_out, wb_we_out, wb_tgts_cr_out - registered copies
//   exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb, exc_code_out - event strobes
//   sleeping, halted        - run-state indicators
module writeback_multi #(
   parameter int DATA_W      = 32,
   parameter int NUM_WR      = 2,
   parameter int MEM_TIMEOUT = 255,
   localparam int OFF_W      = $clog2(DATA_W / 8)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clk_en,
   input  logic                     bubble_in,
   input  logic [NUM_WR-1:0]        wr_req,
   input  logic [5*NUM_WR-1:0]      tgt_in,
   input  logic [DATA_W*NUM_WR-1:0] alu_result,
   input  logic                     is_load,
   input  logic [1:0]               load_size,
   input  logic                     load_signed,
   input  logic [OFF_W-1:0]         addr_lo,
   input  logic                     mem_valid,
   input  logic [DATA_W-1:0]        mem_result,
   input  logic [7:0]               exc_in,
   input  logic                     tgts_cr,
   input  logic [2:0]               event_op,
   input  logic                     wake_in,
   output logic                     stall_out,
   output logic [NUM_WR-1:0]        we,
   output logic [DATA_W*NUM_WR-1:0] result_out,
   output logic [5*NUM_WR-1:0]      wb_tgt_out,
   output logic [DATA_W*NUM_WR-1:0] wb_result_out,
   output logic [NUM_WR-1:0]        wb_we_out,
   output logic                     wb_tgts_cr_out,
   output logic                     exc_in_wb,
   output logic                     interrupt_in_wb,
   output logic                     tlb_exc_in_wb,
   output logic                     rfe_in_wb,
   output logic                     rfi_in_wb,
   output logic [7:0]               exc_code_out,
   output logic                     sleeping,
   output logic                     halted
);

   typedef enum logic [1:0] {S_RUN, S_WAIT_MEM, S_SLEEP, S_HALT} state_t;

   // Counter value on the last permitted waiting cycle; the RUN cycle that
   // detected the miss counts as the first stall cycle.
   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state;
   logic [15:0] to_cnt;

   logic              live;
   logic              mem_timeout;
   logic [7:0]        eff_code;
   logic              has_exc;
   logic              load_wait;
   logic              cr_wr;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              sbit;
   logic [DATA_W-1:0] load_val;

   assign live        = !bubble_in;
   assign mem_timeout = (state == S_WAIT_MEM) && !mem_valid && (to_cnt == TO_LAST);
   assign eff_code    = mem_timeout ? 8'h84 : exc_in;
   assign has_exc     = live && (eff_code != 8'h00);
   // An excepting load never waits: it retires immediately with its exception.
   assign load_wait   = live && is_load && !mem_valid && (exc_in == 8'h00);

   always_comb begin
      stall_out = 1'b1;
      case (state)
         S_RUN:      stall_out = load_wait;
         // The timeout cycle releases the slot so it retires with the bus error.
         S_WAIT_MEM: stall_out = !mem_valid && !mem_timeout;
         default:    stall_out = 1'b1;
      endcase
   end

   assign exc_code_out    = eff_code;
   assign exc_in_wb       = has_exc && !stall_out;
   assign interrupt_in_wb = exc_in_wb && (eff_code[7:4] == 4'hf);
   assign tlb_exc_in_wb   = exc_in_wb && ((eff_code == 8'h82) || (eff_code == 8'h83));
   assign rfe_in_wb       = live && !has_exc && !stall_out && ((event_op == 3'd1) || (event_op == 3'd2));
   assign rfi_in_wb       = live && !has_exc && !stall_out && (event_op == 3'd2);
   assign cr_wr           = live && tgts_cr && !has_exc && !stall_out;

   // Lane extraction: bytes above the shifted word fill with zero, then the
   // value is masked to the access width and optionally sign-extended.
   always_comb begin
      shifted = mem_result >> {addr_lo, 3'b000};
      mask    = '1;
      sbit    = 1'b0;
      case (load_size)
         2'd1: begin
            mask = DATA_W'(16'hFFFF);
            sbit = shifted[15];
         end
         2'd2: begin
            mask = DATA_W'(8'hFF);
            sbit = shifted[7];
         end
         2'd3: begin
            // A 32-bit access on a 32-bit datapath is simply a full word.
            mask = (DATA_W > 32) ? DATA_W'(32'hFFFF_FFFF) : '1;
            sbit = shifted[31];
         end
         default: begin
            mask = '1;
            sbit = 1'b0;
         end
      endcase
      load_val = (shifted & mask) | ((load_signed && sbit) ? ~mask : '0);
   end

   always_comb begin
      result_out = alu_result;
      if (is_load) result_out[DATA_W-1:0] = load_val;
   end

   always_comb begin
      we = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         we[i] = live && wr_req[i] && (tgt_in[5*i +: 5] != 5'd0) && !has_exc && !stall_out;
      end
      we[0] = we[0] && !tgts_cr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_RUN;
         to_cnt         <= '0;
         sleeping       <= 1'b0;
         halted         <= 1'b0;
         wb_tgt_out     <= '0;
         wb_result_out  <= '0;
         wb_we_out      <= '0;
         wb_tgts_cr_out <= 1'b0;
      end else if (clk_en) begin
         wb_tgt_out     <= tgt_in;
         wb_result_out  <= result_out;
         wb_we_out      <= we;
         wb_tgts_cr_out <= cr_wr;
         case (state)
            S_RUN: begin
               if (load_wait) begin
                  state  <= S_WAIT_MEM;
                  to_cnt <= '0;
               end else if (live && !has_exc && (event_op == 3'd4)) begin
                  state    <= S_SLEEP;
                  sleeping <= 1'b1;
               end else if (live && !has_exc && (event_op == 3'd3)) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end
            end
            S_WAIT_MEM: begin
               if (mem_valid || mem_timeout) state <= S_RUN;
               else                          to_cnt <= to_cnt + 16'd1;
            end
            S_SLEEP: begin
               if (wake_in) begin
                  state    <= S_RUN;
                  sleeping <= 1'b0;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_multi.sv
module tb_writeback_multi;
   localparam int DW = 32;
   localparam int NW = 2;
   localparam int MT = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           clk_en;
   logic           bubble_in;
   logic [NW-1:0]  wr_req;
   logic [5*NW-1:0] tgt_in;
   logic [DW*NW-1:0] alu_result;
   logic           is_load;
   logic [1:0]     load_size;
   logic           load_signed;
   logic [1:0]     addr_lo;
   logic           mem_valid;
   logic [DW-1:0]  mem_result;
   logic [7:0]     exc_in;
   logic           tgts_cr;
   logic [2:0]     event_op;
   logic           wake_in;
   logic           stall_out;
   logic [NW-1:0]  we;
   logic [DW*NW-1:0] result_out;
   logic [5*NW-1:0] wb_tgt_out;
   logic [DW*NW-1:0] wb_result_out;
   logic [NW-1:0]  wb_we_out;
   logic           wb_tgts_cr_out;
   logic           exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb;
   logic [7:0]     exc_code_out;
   logic           sleeping, halted;

   int tests = 0;
   int fails = 0;

   writeback_multi #(.DATA_W(DW), .NUM_WR(NW), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bubble_in(bubble_in),
      .wr_req(wr_req), .tgt_in(tgt_in), .alu_result(alu_result),
      .is_load(is_load), .load_size(load_size), .load_signed(load_signed),
      .addr_lo(addr_lo), .mem_valid(mem_valid), .mem_result(mem_result),
      .exc_in(exc_in), .tgts_cr(tgts_cr), .event_op(event_op), .wake_in(wake_in),
      .stall_out(stall_out), .we(we), .result_out(result_out),
      .wb_tgt_out(wb_tgt_out), .wb_result_out(wb_result_out), .wb_we_out(wb_we_out),
      .wb_tgts_cr_out(wb_tgts_cr_out), .exc_in_wb(exc_in_wb),
      .interrupt_in_wb(interrupt_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb),
      .rfe_in_wb(rfe_in_wb), .rfi_in_wb(rfi_in_wb), .exc_code_out(exc_code_out),
      .sleeping(sleeping), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Load value from plain arithmetic: shift down, reduce modulo 2^width,
   // then map the upper half of the range to negative numbers if signed.
   function automatic logic [31:0] m_extract(input logic [31:0] mem, input int off,
                                             input int sz, input bit sgn);
      logic [63:0] v;
      int w;
      v = 64'(mem) >> (8 * off);
      w = (sz == 1) ? 16 : (sz == 2) ? 8 : 32;
      if (w < 32) begin
         v = v % (64'd1 << w);
         if (sgn && v >= (64'd1 << (w - 1))) v = v + (64'd1 << 32) - (64'd1 << w);
      end
      return v[31:0];
   endfunction

   // ---------------- reference model ----------------
   // mode: 0 running, 1 sleeping, 2 halted. wcnt counts stall cycles already
   // spent on the outstanding load (including the cycle that missed).
   int          m_mode, p_mode;
   bit          m_wait, p_wait;
   int          m_wcnt, p_wcnt;
   logic [9:0]  e_wtgt, p_wtgt;
   logic [63:0] e_wres, p_wres;
   logic [1:0]  e_wwe, p_wwe;
   logic        e_wcr, p_wcr;

   always @(negedge clk) begin : model
      bit live, to, stl, exc, xcr;
      logic [7:0] code;
      logic [1:0] xwe;
      logic [63:0] xres;
      if (!rst_n) begin
         m_mode = 0; m_wait = 0; m_wcnt = 0; p_mode = 0; p_wait = 0; p_wcnt = 0;
         e_wtgt = '0; e_wres = '0; e_wwe = '0; e_wcr = 0;
         p_wtgt = '0; p_wres = '0; p_wwe = '0; p_wcr = 0;
         chk("rst_wb_tgt", wb_tgt_out, 0);
         chk("rst_wb_result", wb_result_out, 0);
         chk("rst_wb_we", wb_we_out, 0);
         chk("rst_wb_cr", wb_tgts_cr_out, 0);
         chk("rst_state", {sleeping, halted}, 0);
      end else begin
         m_mode = p_mode; m_wait = p_wait; m_wcnt = p_wcnt;
         e_wtgt = p_wtgt; e_wres = p_wres; e_wwe = p_wwe; e_wcr = p_wcr;
         live = !bubble_in;
         to = 0;
         if (m_mode != 0) stl = 1;
         else if (m_wait) begin
            to  = !mem_valid && (m_wcnt == MT);
            stl = !mem_valid && !to;
         end else stl = live && is_load && !mem_valid && (exc_in == 8'h00);
         code = to ? 8'h84 : exc_in;
         exc  = live && (code != 8'h00);
         for (int p = 0; p < NW; p++)
            xwe[p] = live && wr_req[p] && (tgt_in[5*p +: 5] != 0) && !exc && !stl
                     && (p != 0 || !tgts_cr);
         xcr  = live && tgts_cr && !exc && !stl;
         xres = {alu_result[63:32],
                 is_load ? m_extract(mem_result, int'(addr_lo), int'(load_size), load_signed)
                         : alu_result[31:0]};
         chk("m_stall", stall_out, stl);
         chk("m_we", we, xwe);
         chk("m_result", result_out, xres);
         chk("m_exc", exc_in_wb, exc && !stl);
         chk("m_int", interrupt_in_wb, exc && !stl && code[7:4] == 4'hf);
         chk("m_tlb", tlb_exc_in_wb, exc && !stl && (code == 8'h82 || code == 8'h83));
         chk("m_rfe", rfe_in_wb, live && !exc && !stl && (event_op == 1 || event_op == 2));
         chk("m_rfi", rfi_in_wb, live && !exc && !stl && event_op == 2);
         if (!stl) chk("m_code", exc_code_out, code);
         chk("m_sleeping", sleeping, m_mode == 1);
         chk("m_halted", halted, m_mode == 2);
         chk("m_wb_tgt", wb_tgt_out, e_wtgt);
         chk("m_wb_result", wb_result_out, e_wres);
         chk("m_wb_we", wb_we_out, e_wwe);
         chk("m_wb_cr", wb_tgts_cr_out, e_wcr);
         if (clk_en) begin
            p_wtgt = tgt_in; p_wres = xres; p_wwe = xwe; p_wcr = xcr;
            if (m_mode == 1) begin
               if (wake_in) p_mode = 0;
            end else if (m_mode == 0) begin
               if (m_wait) begin
                  if (mem_valid || to) begin p_wait = 0; p_wcnt = 0; end
                  else p_wcnt = m_wcnt + 1;
               end else if (stl) begin
                  p_wait = 1; p_wcnt = 1;
               end else if (live && !exc && event_op == 3'd4) p_mode = 1;
               else if (live && !exc && event_op == 3'd3) p_mode = 2;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct packed {
      logic [31:0] mem;
      logic [1:0]  off;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] exp;
   } xv_t;

   xv_t xv [7] = '{
      '{32'h80FF_1234, 2'd3, 2'd2, 1'b1, 32'hFFFF_FF80},
      '{32'h80FF_1234, 2'd2, 2'd1, 1'b0, 32'h0000_80FF},
      '{32'h80FF_1234, 2'd2, 2'd1, 1'b1, 32'hFFFF_80FF},
      '{32'h80FF_1234, 2'd1, 2'd0, 1'b1, 32'h0080_FF12},
      '{32'h80FF_1234, 2'd0, 2'd3, 1'b1, 32'h80FF_1234},
      '{32'h80FF_1234, 2'd1, 2'd2, 1'b1, 32'h0000_0012},
      '{32'h80FF_1234, 2'd0, 2'd1, 1'b1, 32'h0000_1234}
   };

   task automatic idle();
      clk_en = 1'b1; bubble_in = 1'b1; wr_req = '0; tgt_in = '0; alu_result = '0;
      is_load = 1'b0; load_size = 2'd0; load_signed = 1'b0; addr_lo = '0;
      mem_valid = 1'b0; mem_result = '0; exc_in = 8'h00; tgts_cr = 1'b0;
      event_op = 3'd0; wake_in = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mid();
      chk("reset_stall", stall_out, 0);
      chk("reset_wb_result", wb_result_out, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // clk_en low: registered copies hold
      bubble_in = 1'b0; wr_req = 2'b11; tgt_in = {5'd4, 5'd3};
      alu_result = 64'hBBBB_0002_AAAA_0001; clk_en = 1'b0;
      mid(); chk("hold_we_comb", we, 2'b11);
      tick(); mid(); chk("hold_wb_we", wb_we_out, 2'b00);
      tick(); clk_en = 1'b1;
      tick(); mid();
      chk("enable_wb_we", wb_we_out, 2'b11);
      chk("enable_wb_result", wb_result_out, 64'hBBBB_0002_AAAA_0001);
      tick();

      // load lane extraction table
      for (int i = 0; i < 7; i++) begin
         idle();
         bubble_in = 1'b0; is_load = 1'b1; mem_valid = 1'b1; mem_result = xv[i].mem;
         addr_lo = xv[i].off; load_size = xv[i].sz; load_signed = xv[i].sgn;
         wr_req = 2'b01; tgt_in = {5'd0, 5'(i + 1)};
         alu_result = {32'h1111_0000 + 32'(i), 32'h0000_CCCC};
         mid();
         chk($sformatf("extract_%0d", i), result_out[31:0], xv[i].exp);
         chk($sformatf("extract_we_%0d", i), we, 2'b01);
         if (i > 0) chk($sformatf("extract_wb_%0d", i - 1), wb_result_out[31:0], xv[i-1].exp);
         tick();
      end
      idle(); mid(); chk("extract_wb_last", wb_result_out[31:0], 32'h0000_1234);
      tick();

      // load waits three cycles for memory
      bubble_in = 1'b0; is_load = 1'b1; wr_req = 2'b01; tgt_in = {5'd0, 5'd9};
      for (int i = 0; i < 3; i++) begin
         mid(); chk("wait_stall", stall_out, 1); chk("wait_we", we, 2'b00);
         tick();
      end
      mem_valid = 1'b1; mem_result = 32'hDEAD_BEEF;
      mid();
      chk("wait_done_stall", stall_out, 0);
      chk("wait_done_we", we, 2'b01);
      chk("wait_done_val", result_out[31:0], 32'hDEAD_BEEF);
      tick(); idle(); mid();
      chk("wait_run", {sleeping, halted, stall_out}, 3'b000);
      chk("wait_wb", wb_result_out[31:0], 32'hDEAD_BEEF);
      tick();

      // memory never answers: timeout after MT stall cycles
      bubble_in = 1'b0; is_load = 1'b1; wr_req = 2'b01; tgt_in = {5'd0, 5'd9};
      for (int i = 0; i < MT; i++) begin
         mid(); chk("to_stall", stall_out, 1); tick();
      end
      mid();
      chk("to_release", stall_out, 0);
      chk("to_exc", exc_in_wb, 1);
      chk("to_code", exc_code_out, 8'h84);
      chk("to_we", we, 2'b00);
      tick();
      is_load = 1'b0; wr_req = 2'b11; tgt_in = {5'd4, 5'd3};
      mid(); chk("to_next_we", we, 2'b11); chk("to_next_exc", exc_in_wb, 0);
      tick();

      // wake while running is ignored
      idle(); wake_in = 1'b1;
      tick(); mid(); chk("wake_run", {sleeping, stall_out}, 2'b00);
      tick();

      // sleep, wake after five cycles
      idle(); bubble_in = 1'b0; event_op = 3'd4;
      mid(); chk("sleep_issue", stall_out, 0);
      tick(); idle();
      for (int i = 0; i < 5; i++) begin
         mid(); chk("sleep_hold", {sleeping, stall_out}, 2'b11); tick();
      end
      wake_in = 1'b1;
      mid(); chk("sleep_wake_cyc", sleeping, 1);
      tick(); wake_in = 1'b0;
      mid(); chk("sleep_exit", {sleeping, stall_out}, 2'b00);
      tick();

      // halt with TLB exception: exception wins
      bubble_in = 1'b0; event_op = 3'd3; exc_in = 8'h82;
      mid(); chk("halt_tlb", tlb_exc_in_wb, 1); chk("halt_int", interrupt_in_wb, 0);
      tick(); idle();
      mid(); chk("halt_exc_noenter", halted, 0);
      tick();

      // interrupt, rfe, rfi
      bubble_in = 1'b0; exc_in = 8'hF3;
      mid(); chk("int_strobe", interrupt_in_wb, 1); chk("int_tlb", tlb_exc_in_wb, 0);
      tick(); exc_in = 8'h00; event_op = 3'd1;
      mid(); chk("rfe_only", {rfe_in_wb, rfi_in_wb}, 2'b10);
      tick(); event_op = 3'd2;
      mid(); chk("rfi_both", {rfe_in_wb, rfi_in_wb}, 2'b11);
      tick();

      // control-register target, port 1 to r0
      idle(); bubble_in = 1'b0; wr_req = 2'b11; tgt_in = {5'd0, 5'd7}; tgts_cr = 1'b1;
      alu_result = 64'h0000_0055_0000_0066;
      mid(); chk("cr_we", we, 2'b00);
      tick(); idle();
      mid(); chk("cr_wb", wb_tgts_cr_out, 1);
      tick();

      // halt, then asynchronous reset while halted
      bubble_in = 1'b0; event_op = 3'd3; wr_req = 2'b01; tgt_in = {5'd0, 5'd5};
      alu_result = 64'h0000_0001_0000_0123;
      tick(); event_op = 3'd0;
      mid(); chk("halt_enter", {halted, stall_out}, 2'b11);
      tick(); tick();
      mid(); chk("halt_stays", halted, 1); chk("halt_wb_pre", wb_result_out, 64'h0000_0001_0000_0123);
      tick();
      rst_n = 1'b0;
      #1;
      chk("areset_halted", halted, 0);
      chk("areset_wb_tgt", wb_tgt_out, 0);
      chk("areset_wb_result", wb_result_out, 0);
      chk("areset_wb_we", wb_we_out, 0);
      tick(); rst_n = 1'b1; idle();
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/writeback_multi.md
Name: writeback_multi

Overview:
- Parametrised next-generation writeback stage: DATA_W-wide datapath, NUM_WR GPR write ports, sized and signed load-lane extraction, and variable-latency load completion with a stall handshake and timeout.
- Sits after the memory stage. Owns the core run state (run / wait-for-memory / sleep / halt) and emits architectural control events for the live slot.

Parameters:
- DATA_W, 32, datapath width; legal values are 32 and 64. OFF_W = log2(DATA_W/8).
- NUM_WR, 2, number of GPR write ports. Port 0 is the only one that can carry a load result.
- MEM_TIMEOUT, 255, maximum cycles spent in WAIT_MEM before a bus-error exception. Range 1..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  stage advance enable. When low, all state and registers hold.
- bubble_in  in  1  slot is a bubble. Live = !bubble_in.
- wr_req  in  NUM_WR  per-port write request.
- tgt_in  in  5*NUM_WR  per-port target register.
- alu_result  in  DATA_W*NUM_WR  per-port ALU value.
- is_load  in  1  port 0 takes its value from memory.
- load_size  in  2  0=full, 1=16b, 2=8b, 3=32b.
- load_signed  in  1  sign-extend the extracted value.
- addr_lo  in  OFF_W  byte offset of the load.
- mem_valid  in  1  mem_result is valid this cycle.
- mem_result  in  DATA_W  raw memory word.
- exc_in  in  8  exception code; 0 = none.
- tgts_cr  in  1  port 0 targets a control register.
- event_op  in  3  0=none, 1=rfe, 2=rfi, 3=halt, 4=sleep.
- wake_in  in  1  wake request from interrupt controller.
- stall_out  out  1  upstream must hold the slot.
- we  out  NUM_WR  combinational write enables.
- result_out  out  DATA_W*NUM_WR  combinational write values (forwarding path).
- wb_tgt_out, wb_result_out, wb_we_out  out  per-port  registered copies of tgt/result/we.
- wb_tgts_cr_out  out  1  registered control-register write strobe.
- exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb  out  1 each  event strobes.
- exc_code_out  out  8  effective exception code.
- sleeping, halted  out  1 each  current state is SLEEP / HALT.

Behaviour:
- Reset: state=RUN, timeout counter=0, and every registered output = 0.
- States:
  - RUN → WAIT_MEM when a live non-excepting load has mem_valid=0.
  - RUN → SLEEP on a live non-excepting sleep.
  - RUN → HALT on a live non-excepting halt.
  - WAIT_MEM → RUN when mem_valid=1.
  - WAIT_MEM → RUN with a bus error when the counter reaches MEM_TIMEOUT.
  - SLEEP → RUN the cycle after wake_in=1.
  - HALT exits only via reset.
- Transitions and counting occur only when clk_en=1.
- stall_out = 1 in any of these cases:
  - in RUN, a live load with mem_valid=0;
  - in WAIT_MEM, mem_valid=0;
  - in SLEEP or HALT.
- A load completes, with zero added latency, in the cycle mem_valid=1.
- Timeout counter: clears on entry to WAIT_MEM and increments each clk_en cycle while waiting. On reaching MEM_TIMEOUT, exc_code_out=8'h84 for one cycle, we=0, and state returns to RUN.
- Effective exception: exc_code_out = exc_in, or 8'h84 on timeout.
  - exc_in_wb = live && code != 0.
  - interrupt_in_wb = live && code[7:4] == 4'hf.
  - tlb_exc_in_wb = exc_in_wb && code ∈ {8'h82, 8'h83}.
- rfe_in_wb = live, no exception, event_op ∈ {1,2}. rfi_in_wb = same conditions with event_op = 2.
- All strobes are zero while stall_out=1, except a bus error on the timeout cycle.
- we[i] = live && wr_req[i] && tgt[i] != 0 && no exception && !stall_out. Port 0 additionally requires !tgts_cr.
- Load extraction on port 0: v = mem_result >> (8*addr_lo). Bytes shifted in above the top are zero. Then mask to the size width; full means DATA_W.
  - size 3 with DATA_W=32 behaves as full.
  - Signed: replicate bit (width-1) of the masked value.
- result_out[0] = is_load ? extracted value : alu_result[0]. Other ports pass alu_result.
- Registered outputs capture the combinational values on clk when clk_en=1.
  - wb_tgts_cr_out = live && tgts_cr && no exception && !stall_out.
- Reset asserted mid-WAIT_MEM or in SLEEP/HALT returns the block to RUN immediately (asynchronous); no pending write survives.
- Simultaneous exception with halt or sleep: the exception wins and the state stays RUN.
- wake_in while in RUN is ignored.

Test Plan:
- DATA_W=32, live load, size=2, signed, addr_lo=3, mem_result=32'h80FF_1234, mem_valid=1 → result_out[0]=32'hFFFF_FF80, we[0]=1, and wb_result_out[0] shows it one cycle later.
- Live load with mem_valid held low for 3 cycles, then word 32'hDEADBEEF → stall_out=1 for 3 cycles and we[0]=0 throughout; on the 4th cycle we[0]=1 with value DEADBEEF and state=RUN.
- MEM_TIMEOUT=4, mem_valid never asserted → 4 stall cycles, then exc_in_wb=1 with exc_code_out=8'h84, we=0, and the next slot proceeds.
- Live sleep, then wake_in after 5 cycles → sleeping=1 and stall_out=1 for those cycles; returns to RUN the cycle after wake. Halt with exc_in=8'h82 → tlb_exc_in_wb=1, halted stays 0.
- NUM_WR=2: both ports write, port 1 tgt=0, tgts_cr=1 → we=2'b00 and wb_tgts_cr_out=1. Assert rst_n low while in HALT → halted=0 and all registered outputs 0 immediately.
